// File: rtl/lcd_rx_pkg.sv
// rtl/lcd_rx_pkg.sv - shared panel constants, rx state and RGB565 types
package lcd_rx_pkg;

    localparam int H_ACTIVE_DEF       = 480;
    localparam int V_ACTIVE_DEF       = 272;
    localparam int VBLANK_MIN_GAP_DEF = 1024;

    typedef enum logic [1:0] {
        SEARCH,
        ARMED,
        LINE,
        HBLANK
    } rx_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lcd_rx_gap_det.sv
// rtl/lcd_rx_gap_det.sv - stage-1 DE register, edge detect and DE-low run-length counter
module lcd_rx_gap_det #(
    parameter int VBLANK_MIN_GAP = 1024
) (
    input  logic PixelClk,
    input  logic nRST,
    input  logic de,
    output logic de_rise,
    output logic de_fall,
    output logic vblank
);

    localparam int            CW    = $clog2(VBLANK_MIN_GAP + 1);
    localparam logic [CW-1:0] GAP_W = CW'(VBLANK_MIN_GAP);

    logic          de_s1;
    logic          de_prev;
    logic [CW-1:0] gap_cnt;

    // gap_cnt is fed from the pin so it always equals the low run ending at de_s1
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_s1   <= 1'b0;
            de_prev <= 1'b0;
            gap_cnt <= '0;
        end else begin
            de_s1   <= de;
            de_prev <= de_s1;
            if (de)
                gap_cnt <= '0;
            else if (gap_cnt != GAP_W)
                gap_cnt <= gap_cnt + 1'b1;
        end
    end

    assign de_rise = de_s1 & ~de_prev;
    assign de_fall = ~de_s1 & de_prev;
    assign vblank  = (gap_cnt == GAP_W);

endmodule

// File: rtl/lcd_rx.sv
// rtl/lcd_rx.sv - DE-only RGB565 receiver with frame recovery and geometry check
module lcd_rx
    import lcd_rx_pkg::*;
#(
    parameter int H_ACTIVE       = H_ACTIVE_DEF,
    parameter int V_ACTIVE       = V_ACTIVE_DEF,
    parameter int VBLANK_MIN_GAP = VBLANK_MIN_GAP_DEF
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        LCD_DE,
    input  logic [4:0]  LCD_R,
    input  logic [5:0]  LCD_G,
    input  logic [4:0]  LCD_B,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done,
    output logic [15:0] meas_width,
    output logic [15:0] meas_height,
    output logic        err_width,
    output logic        err_height,
    output logic        locked,
    output logic [7:0]  frame_count
);

    localparam logic [15:0] H_EXP = 16'(H_ACTIVE);
    localparam logic [15:0] V_EXP = 16'(V_ACTIVE);

    logic        de_rise;
    logic        de_fall;
    logic        vblank;
    rgb565_t     rgb_s1;
    rx_state_t   state;
    logic [15:0] x_cnt;
    logic [15:0] y_cnt;
    logic [15:0] wk_width;
    logic        wk_err_w;
    logic [15:0] height_n;
    logic        height_bad;

    lcd_rx_gap_det #(
        .VBLANK_MIN_GAP(VBLANK_MIN_GAP)
    ) u_gap_det (
        .PixelClk(PixelClk),
        .nRST    (nRST),
        .de      (LCD_DE),
        .de_rise (de_rise),
        .de_fall (de_fall),
        .vblank  (vblank)
    );

    assign height_n   = sat_inc16(y_cnt);
    assign height_bad = (height_n != V_EXP);

    // Stage 2: the emitted pixel is the stage-1 sample; the pin DE is its successor, hence eol
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            rgb_s1      <= '0;
            state       <= SEARCH;
            x_cnt       <= '0;
            y_cnt       <= '0;
            wk_width    <= '0;
            wk_err_w    <= 1'b0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            frame_done  <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            err_width   <= 1'b0;
            err_height  <= 1'b0;
            locked      <= 1'b0;
            frame_count <= '0;
        end else begin
            rgb_s1     <= '{r: LCD_R, g: LCD_G, b: LCD_B};
            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                SEARCH: begin
                    if (vblank)
                        state <= ARMED;
                end
                ARMED: begin
                    if (de_rise) begin
                        pix_valid <= 1'b1;
                        pix_data  <= rgb_s1;
                        pix_x     <= 16'd0;
                        pix_y     <= 16'd0;
                        pix_sof   <= 1'b1;
                        pix_eol   <= ~LCD_DE;
                        x_cnt     <= 16'd1;
                        y_cnt     <= 16'd0;
                        wk_err_w  <= 1'b0;
                        state     <= LINE;
                    end
                end
                LINE: begin
                    if (de_fall) begin
                        if (y_cnt == 16'd0)
                            wk_width <= x_cnt;
                        if (x_cnt != H_EXP)
                            wk_err_w <= 1'b1;
                        state <= HBLANK;
                    end else begin
                        pix_valid <= 1'b1;
                        pix_data  <= rgb_s1;
                        pix_x     <= x_cnt;
                        pix_y     <= y_cnt;
                        pix_eol   <= ~LCD_DE;
                        x_cnt     <= sat_inc16(x_cnt);
                    end
                end
                HBLANK: begin
                    if (vblank) begin
                        frame_done  <= 1'b1;
                        meas_width  <= wk_width;
                        meas_height <= height_n;
                        err_width   <= wk_err_w;
                        err_height  <= height_bad;
                        locked      <= ~(wk_err_w | height_bad);
                        frame_count <= frame_count + 8'd1;
                        wk_err_w    <= 1'b0;
                        state       <= ARMED;
                    end else if (de_rise) begin
                        pix_valid <= 1'b1;
                        pix_data  <= rgb_s1;
                        pix_x     <= 16'd0;
                        pix_y     <= height_n;
                        pix_eol   <= ~LCD_DE;
                        x_cnt     <= 16'd1;
                        y_cnt     <= height_n;
                        state     <= LINE;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule
